timer_device: RTL
=================

# timer_device

Programmable down-counting timer that sits on the processor's peripheral bus and drives one bit of the CP0 `HWInt[5:0]` interrupt vector. It is the interrupt-source end of the interrupt path: software programs it through three word registers, and it raises `irq` when the count expires. It supports a one-shot mode with a sticky interrupt and an auto-reload mode with a one-cycle interrupt pulse.

## Interface
- No parameters; register map and field positions are fixed constants in `timer_pkg`.
- `clk  in  1`: system clock; all state changes on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `addr  in  [3:2]`: word select. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `we  in  1`: write strobe for the word at `addr`; the write takes effect at the rising edge.
- `din  in  32`: write data.
- `dout  out  32`: combinational read data for `addr`.
- `irq  out  1`: interrupt request to one CP0 `HWInt` bit; driven directly from a register.

## Operation
- **CTRL fields:** [0] EN (enable), [2:1] MODE, [3] IM (interrupt mask). Bits [31:4] read 0.
  - MODE 0: one-shot. MODE 1: auto-reload. MODEs 2 and 3 behave as MODE 0.
- **PRESET:** 32-bit reload value, read/write.
- **COUNT:** 32-bit, read-only; writes are ignored. Address 3 reads 0 and ignores writes.
- **`irq` = `pend` & IM.** `pend` is an internal flag.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: when EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds its value.
    - Else if COUNT <= 1: COUNT <= 0, `pend` <= 1, go to INT.
    - Else COUNT <= COUNT - 1.
  - INT, MODE 0: EN <= 0, go to IDLE. `pend` stays 1 until any bus write to CTRL or PRESET.
  - INT, MODE 1: `pend` <= 0, go to LOAD. Result is a one-cycle pulse; period is PRESET+2 cycles for PRESET >= 1.
  - INT with EN=0: go to IDLE.
- **Arithmetic:** unsigned 32-bit decrement. COUNT never wraps below 0. PRESET=0 behaves as PRESET=1.
- **PRESET writes** during CNT do not affect the running COUNT; they are used at the next LOAD.
- **Simultaneous events:**
  - Bus write to CTRL in the same cycle the FSM clears EN in INT: the written EN wins.
  - Clearing write to CTRL/PRESET in the same cycle `pend` is set by CNT→INT: the set wins, so no interrupt is lost.
- **Reset (any time, including mid-count):** CTRL=0, PRESET=0, COUNT=0, `pend`=0, state IDLE.
  - Outputs during and after reset: `irq`=0, `dout`=0 for every address.

## Timing
- Write latency: register contents update at the edge where `we`=1; `dout` shows the new value in the following cycle.
- Write of EN=1 at edge W, with PRESET=P, P>=1:
  - W+1: state LOAD.
  - W+2: state CNT, COUNT=P.
  - W+P+1: COUNT=1.
  - W+P+2: COUNT=0, state INT, `pend`=1. `irq` rises at this edge if IM=1.
  - W+P+3: state IDLE (MODE 0) or LOAD (MODE 1). In MODE 1, `irq` falls at this edge.
- `irq` is glitch-free (register AND a CTRL register bit). CP0 samples it once per cycle, so the MODE 1 one-cycle pulse is sufficient.
- Clearing EN mid-count stops the counter within 1 cycle. Setting EN again restarts from LOAD; it does not resume.

## Structure
- `timer_pkg` holds:
  - Address constants CTRL=2'd0, PRESET=2'd1, COUNT=2'd2.
  - CTRL bit positions: EN, MODE lsb/msb, IM.
  - MODE encodings.
  - The 2-bit FSM state encoding.
- Single module; no sub-module needed. Register file, read mux, and FSM all live in `timer_device`.
- Top-level integration: `irq` connects to `HWInt[0]` of CP0. The bus decoder gates `we` by address range.

## Test plan
- Reset: hold `rst_n`=0 mid-count with PRESET=5. Required: `irq`=0, all three reads return 0, and the state returns to IDLE immediately, asynchronously.
- One-shot: PRESET=3, then CTRL=0x9 (EN, MODE 0, IM) at edge W.
  - `irq` rises at W+5 and stays high. CTRL reads 0x8 from W+6.
  - Writing CTRL=0x8 drops `irq` the next cycle.
- Auto-reload: PRESET=2, CTRL=0xB.
  - `irq` is a 1-cycle pulse every 4 cycles. COUNT reads the sequence 2,1,0,0,2,…
  - 3 pulses are seen in 12 cycles.
- Mask and restart:
  - IM=0, MODE 0, PRESET=1: `irq` stays 0. Then write CTRL=0x8 (IM=1): `irq` stays 0, because the CTRL write clears `pend`.
  - Clear EN at COUNT=5 of PRESET=10: COUNT holds 5. Setting EN again reloads 10.
- Simultaneous events: write PRESET in the same cycle CNT→INT sets `pend`; required `irq`=1. Write CTRL EN=1 in the INT cycle in MODE 0; required EN reads 1 and the FSM reloads.
- Boundaries:
  - PRESET=0 and PRESET=1 both raise `irq` at W+3.
  - PRESET=0xFFFFFFFF: COUNT decrements to 0xFFFFFFFE at W+3.
  - A write to COUNT or to address 3 changes nothing.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the bus timer: register map, CTRL field positions,
// mode encodings and FSM state encoding.
package timer_pkg;

  // Word addresses (bus address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  // MODE encodings; 2 and 3 fall back to one-shot behaviour
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1
  } mode_e;

  // Counter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_device_if.sv
// Peripheral bus port of the timer: word select, write strobe, write data
// and combinational read data.
interface timer_device_if;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_device.sv
// Programmable down-counting timer with one-shot (sticky interrupt) and
// auto-reload (one-cycle pulse) modes. Drives one CP0 HWInt bit via irq.
module timer_device
  import timer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  timer_device_if.slave  bus,
  output logic           irq
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  state_e      state_q, state_d;

  logic        en;
  logic [1:0]  mode;
  logic        wr_ctrl;
  logic        wr_preset;

  assign en        = ctrl_q[CTRL_EN];
  assign mode      = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_preset = bus.we && (bus.addr == ADDR_PRESET);

  // The interrupt is a flop ANDed with a CTRL flop, so it cannot glitch.
  assign irq = pend_q & ctrl_q[CTRL_IM];

  // Next-state logic: bus writes first, then FSM actions, so that a
  // pend set overrides a bus clear and a CTRL write overrides the FSM EN clear.
  always_comb begin
    // NOTE: every target gets a hold-value default first so no path leaves it unassigned (no latch).
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    state_d  = state_q;

    if (wr_ctrl)   ctrl_d   = bus.din[3:0];
    if (wr_preset) preset_d = bus.din;
    if (wr_ctrl || wr_preset) pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          // PRESET=0 lands here straight from LOAD, so it acts like PRESET=1
          count_d = 32'd0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (mode == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          if (!wr_ctrl) ctrl_d[CTRL_EN] = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset to the idle, all-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
    end
  end

  // Read mux; zero for the unmapped word.
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = {28'd0, ctrl_q};
      ADDR_PRESET: bus.dout = preset_q;
      ADDR_COUNT:  bus.dout = count_q;
      default:     bus.dout = '0;
    endcase
  end

endmodule
